// File: rtl/dmem_latency_model.sv
// Line-wide (256-bit) data memory with a fixed request-to-commit latency and a one-cycle ack pulse.
// Optional macro DMEM_RANGE_CHECK_EN adds err_o and flags requests with addr_i[31:14] != 0.
module dmem_latency_model #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic         err_o
`endif
);

  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [8:0]   idx_q, idx_d;
  logic [255:0] wdata_q, wdata_d;
  logic         wr_q, wr_d;
  logic         oob_q, oob_d;
  logic         ack_q, ack_d;
  logic [255:0] data_q, data_d;
  logic         err_q, err_d;

  logic         accept;
  logic         commit;
  logic         mem_we;
  logic [255:0] rd_line;

  // Contents are deliberately left out of reset; only the control path is cleared.
  logic [255:0] mem [DEPTH];

  assign accept  = (state_q == S_IDLE) && enable_i;
  assign commit  = (state_q == S_WAIT) && (cnt_q == LAST_CNT);
  assign mem_we  = commit && wr_q && !oob_q;
  assign rd_line = mem[idx_q];

`ifdef DMEM_RANGE_CHECK_EN
  logic [4:0] unused_addr_bits;
  assign unused_addr_bits = addr_i[4:0];
`else
  logic [22:0] unused_addr_bits;
  assign unused_addr_bits = {addr_i[31:14], addr_i[4:0]};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_i) state_d = S_WAIT;
      S_WAIT:  if (commit)   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    oob_d   = oob_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    if (accept) begin
      cnt_d   = 8'd0;
      idx_d   = addr_i[13:5];
      wdata_d = data_i;
      wr_d    = write_i;
`ifdef DMEM_RANGE_CHECK_EN
      oob_d   = |addr_i[31:14];
`else
      oob_d   = 1'b0;
`endif
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Writes never touch data_o; it only changes when a read commits.
    if (commit) begin
      ack_d = 1'b1;
      err_d = oob_q;
      if (!wr_q) begin
        data_d = oob_q ? '1 : rd_line;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 8'd0;
      idx_q   <= 9'd0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign err_o  = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_latency_model.sv
// Randomized self-checking bench for dmem_latency_model against a line-array reference model.
module tb_dmem_latency_model;

  localparam int L = 10;
  localparam logic [255:0] A5 = {32{8'hA5}};

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
`ifdef DMEM_RANGE_CHECK_EN
  logic         err_o;
`endif

  dmem_latency_model #(.LATENCY(L), .DEPTH(512)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int n_req    = 0;

  logic [255:0] model_mem [512];
  logic [255:0] exp_dout;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue one request from a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w,
                         input bit scramble, output logic [255:0] dout_ack);
    int   first;
    int   pulses;
    int   idx;
    bit   oob;
    logic err_seen;
    idx = int'(a[13:5]);
`ifdef DMEM_RANGE_CHECK_EN
    oob = (a[31:14] != 18'd0);
`else
    oob = 1'b0;
`endif
    addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
    @(negedge clk_i);
    first = -1; pulses = 0; dout_ack = '0; err_seen = 1'b0;
    for (int c = 1; c <= L + 1; c++) begin
      if (scramble) begin
        addr_i  = $urandom;
        data_i  = rand256();
        write_i = 1'($urandom);
      end
      @(negedge clk_i);
      if (ack_o) begin
        pulses++;
        if (first < 0) begin
          first    = c;
          dout_ack = data_o;
`ifdef DMEM_RANGE_CHECK_EN
          err_seen = err_o;
`endif
        end
      end
    end
    enable_i = 1'b0; addr_i = '0; data_i = '0; write_i = 1'b0;
    if (w && !oob) model_mem[idx] = d;
    if (!w) exp_dout = oob ? '1 : model_mem[idx];
    check("ack_latency", first, L);
    check("ack_pulses", pulses, 1);
    check("dout_at_ack", dout_ack, exp_dout);
    check("dout_held", data_o, exp_dout);
`ifdef DMEM_RANGE_CHECK_EN
    check("err_at_ack", err_seen, oob);
`endif
    n_req++;
    $display("req %0d addr=%h wr=%0d scr=%0d lat=%0d line=%0d", n_req, a, w, scramble, first, idx);
  endtask

  initial begin
    logic [255:0] d, got, old4;
    int pulses;
    int ack_at[$];
    logic [255:0] dout2;
    logic [31:0] a;
    logic [17:0] hi;
    logic [8:0]  line;

    rst_i = 1'b1; enable_i = 1'b0; addr_i = '0; data_i = '0; write_i = 1'b0;
    exp_dout = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ack", ack_o, 1'b0);
    check("rst_dout", data_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ack", ack_o, 1'b0);

    for (int i = 0; i < 32; i++) begin
      line = 9'(i);
      run_req({18'd0, line, 5'd0}, rand256(), 1'b1, 1'b0, got);
    end

    // Known-pattern write then back-to-back read of the same line
    run_req(32'h0000_0040, A5, 1'b1, 1'b0, got);
    run_req(32'h0000_0040, rand256(), 1'b0, 1'b0, got);
    check("rd_after_wr_a5", got, A5);
    repeat (2) @(negedge clk_i);
    check("dout_hold_2cyc", data_o, A5);

    // Inputs scrambled during WAIT must not disturb the latched request
    d = rand256();
    run_req(32'h0000_0060, d, 1'b1, 1'b1, got);
    run_req(32'h0000_0060, '0, 1'b0, 1'b1, got);
    check("latched_data_used", got, d);

    // Reset in the middle of a write aborts it
    old4 = model_mem[4];
    addr_i = 32'h0000_0080; data_i = ~old4; write_i = 1'b1; enable_i = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #2;
    check("abort_rst_ack", ack_o, 1'b0);
    check("abort_rst_dout", data_o, '0);
    rst_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk_i);
      if (ack_o) pulses++;
    end
    check("abort_no_ack", pulses, 0);
    check("abort_dout_zero", data_o, '0);
    exp_dout = '0;
    $display("req abort addr=00000080 wr=1 reset_at_cnt=5");
    run_req(32'h0000_0080, '0, 1'b0, 1'b0, got);
    check("abort_mem_kept", got, old4);

    // enable_i held through ACK: second request accepted in the next IDLE cycle
    d = rand256();
    addr_i = 32'h0000_0120; data_i = d; write_i = 1'b1; enable_i = 1'b1;
    @(negedge clk_i);
    data_i = rand256(); write_i = 1'b0;
    ack_at.delete();
    dout2 = '0;
    for (int c = 1; c <= 2 * L + 3; c++) begin
      if (c == L + 3) enable_i = 1'b0;
      @(negedge clk_i);
      if (ack_o) begin
        ack_at.push_back(c);
        dout2 = data_o;
      end
    end
    enable_i = 1'b0; addr_i = '0; data_i = '0;
    model_mem[9] = d;
    exp_dout = d;
    check("b2b_ack_count", ack_at.size(), 2);
    if (ack_at.size() == 2) begin
      check("b2b_first_lat", ack_at[0], L);
      check("b2b_spacing", ack_at[1] - ack_at[0], L + 2);
    end
    check("b2b_read_new", dout2, d);
    $display("req b2b addr=00000120 acks=%0d", ack_at.size());

    // Randomized traffic over the preloaded lines
    for (int n = 0; n < 40; n++) begin
      line = 9'($urandom_range(0, 31));
`ifdef DMEM_RANGE_CHECK_EN
      hi = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(1, 262143)) : 18'd0;
`else
      hi = 18'($urandom);
`endif
      a = {hi, line, 5'($urandom)};
      run_req(a, rand256(), 1'($urandom), 1'($urandom), got);
    end

`ifdef DMEM_RANGE_CHECK_EN
    run_req(32'h0001_0000, '0, 1'b0, 1'b0, got);
    check("oob_read_ones", got, '1);
    run_req(32'h0001_0000, ~model_mem[0], 1'b1, 1'b0, got);
    run_req(32'h0000_0000, '0, 1'b0, 1'b0, got);
    check("oob_no_write", got, model_mem[0]);
    check("err_idle_low", err_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
